// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial a - b - borrow_in, LSB first, one bit per clock.
// Ports: clk, rst (sync, active high), start, a_in, b_in, borrow_in ->
//   busy, done (1-cycle pulse), diff, borrow_out, overflow.
module serial_subtractor #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             borrow_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             overflow
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] diff_q;
  logic             br_q;
  logic [CW-1:0]    cnt_q;
  logic             bo_q;
  logic             ov_q;

  logic             d_bit;
  logic             br_d;
  logic             last;

  always_comb begin
    d_bit = a_q[0] ^ b_q[0] ^ br_q;
    br_d  = (~a_q[0] & b_q[0])
          | (~a_q[0] & br_q)
          | (b_q[0] & br_q);
    last  = (cnt_q == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      diff_q  <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      bo_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (start) begin
            a_q     <= a_in;
            b_q     <= b_in;
            br_q    <= borrow_in;
            cnt_q   <= '0;
            state_q <= SHIFT;
          end else begin
            state_q <= IDLE;
          end
        end
        SHIFT: begin
          diff_q <= {d_bit, diff_q[WIDTH-1:1]};
          a_q    <= a_q >> 1;
          b_q    <= b_q >> 1;
          br_q   <= br_d;
          cnt_q  <= cnt_q + CW'(1);
          if (last) begin
            // On the final bit a_q[0]/b_q[0] are the operand MSBs
            // and d_bit is the result MSB.
            state_q <= DONE;
            bo_q    <= br_d;
            ov_q    <= (a_q[0] != b_q[0]) && (d_bit != a_q[0]);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy       = (state_q == SHIFT);
  assign done       = (state_q == DONE);
  assign diff       = diff_q;
  assign borrow_out = bo_q;
  assign overflow   = ov_q;

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, setting the operand and result width in bits.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, synchronous active-high reset sampled on the rising edge of clk.
REQ-004 The block SHALL have port start, input, 1, a request to begin a subtraction.
REQ-005 The block SHALL have port a_in, input, WIDTH, the minuend.
REQ-006 The block SHALL have port b_in, input, WIDTH, the subtrahend.
REQ-007 The block SHALL have port borrow_in, input, 1, the borrow into bit 0.
REQ-008 The block SHALL have port busy, output, 1, high while an operation is in progress.
REQ-009 The block SHALL have port done, output, 1, a one-cycle pulse marking the cycle in which the result becomes valid.
REQ-010 The block SHALL have port diff, output, WIDTH, the result a_in - b_in - borrow_in modulo 2^WIDTH.
REQ-011 The block SHALL have port borrow_out, output, 1, the borrow out of the MSB, high when a_in < b_in + borrow_in as unsigned values.
REQ-012 The block SHALL have port overflow, output, 1, the two's-complement signed overflow of the subtraction.

Function
REQ-013 The block SHALL implement a three-state FSM with states IDLE, SHIFT and DONE.
REQ-014 In IDLE or DONE with start=1, the block SHALL latch a_in, b_in and borrow_in into internal shift registers and the borrow flop, clear the bit counter to 0, and enter SHIFT.
REQ-015 In IDLE or DONE with start=0, the block SHALL go to, or remain in, IDLE.
REQ-016 In SHIFT, each clock SHALL process one bit, LSB first, through a single full-subtractor:
- d = a XOR b XOR br
- br_next = (~a & b) | (~a & br) | (b & br)
REQ-017 In SHIFT, d SHALL shift into the MSB of the diff register; the operand registers SHALL shift right by one; the counter SHALL increment.
REQ-018 On the clock that processes bit WIDTH-1, the block SHALL enter DONE.
REQ-019 Latency: with start sampled at edge N, done SHALL be high between edges N+WIDTH and N+WIDTH+1; for WIDTH=16 this is 16 cycles.
REQ-020 busy SHALL be 1 exactly in SHIFT, and done SHALL be 1 exactly in DONE.
REQ-021 diff, borrow_out and overflow SHALL be valid in DONE and SHALL hold their values until the next accepted start.
REQ-022 overflow SHALL equal (a[MSB] != b[MSB]) AND (diff[MSB] != a[MSB]), using the latched operands.
REQ-023 start while busy=1 SHALL be ignored, and the operands and the operation in flight SHALL be unaffected.
REQ-024 start in DONE SHALL be accepted; back-to-back operations SHALL therefore complete every WIDTH+1 cycles.
REQ-025 Input changes on a_in, b_in or borrow_in after the accepting edge SHALL have no effect on the result.

Reset
REQ-026 When rst=1 at a clock edge, the block SHALL enter IDLE and clear the counter, borrow flop and operand registers, and SHALL drive busy=0, done=0, diff=0, borrow_out=0 and overflow=0 after that edge.
REQ-027 Reset SHALL take priority over start, and a reset asserted during SHIFT SHALL abort the operation with no done pulse.
REQ-028 After rst deasserts, the first start SHALL be accepted normally.

Verification
REQ-029 The bench SHALL cover a basic subtraction: a=10000, b=9, bin=0 -> 16 cycles later done=1, diff=0x2707 (9991), borrow_out=0, overflow=0.
REQ-030 The bench SHALL cover unsigned underflow: a=0, b=1, bin=0 -> diff=0xFFFF, borrow_out=1, overflow=0.
REQ-031 The bench SHALL cover signed overflow and borrow-in:
- a=0x8000, b=1, bin=0 -> diff=0x7FFF, overflow=1, borrow_out=0
- a=5, b=3, bin=1 -> diff=0x0001, borrow_out=0
REQ-032 The bench SHALL cover start while busy: start with a=100, b=1, then pulse start at cycle 5 with a=0, b=0 -> the second start is ignored, diff=0x0063, and exactly one done pulse occurs.
REQ-033 The bench SHALL cover reset mid-operation: rst at cycle 8 of SHIFT -> next cycle busy=0, done=0, diff=0, no done pulse; a new start then completes correctly.
REQ-034 The bench SHALL cover back-to-back operations: start held high through DONE -> two done pulses 17 cycles apart with both results correct.
